// File: rtl/aes_reg_file_p.sv
// Parametrised AES register bank: key/message/result words, start/done handshake, status, irq.
// Optional macro AES_REG_IRQ_EN enables irq, CTRL.irq_en and STAT.err recording.
module aes_reg_file_p #(
    parameter int DATA_W    = 32,
    parameter int KEY_WORDS = 4,
    parameter int MSG_WORDS = 4,
    parameter int ADDR_W    = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          cs,
    input  logic                          r,
    input  logic                          w,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W/8-1:0]           byte_en,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rvalid,
    output logic [KEY_WORDS*DATA_W-1:0]   key_out,
    output logic [MSG_WORDS*DATA_W-1:0]   msg_out,
    output logic                          start_pulse,
    output logic                          busy,
    input  logic [MSG_WORDS*DATA_W-1:0]   dec_in,
    input  logic                          dec_valid,
    input  logic                          done_in,
    output logic                          irq,
    output logic [DATA_W-1:0]             ex
);

`ifdef AES_REG_IRQ_EN
    localparam bit IRQ_FEAT = 1'b1;
`else
    localparam bit IRQ_FEAT = 1'b0;
`endif

    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] STAT_ADDR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0]    key_q [KEY_WORDS];
    logic [DATA_W-1:0]    enc_q [MSG_WORDS];
    logic [DATA_W-1:0]    dec_q [MSG_WORDS];
    logic                 done_q, err_q, irq_en_q;
    logic [KEY_WORDS-1:0] key_hit;
    logic [MSG_WORDS-1:0] enc_hit;
    logic [DATA_W-1:0]    wmask;
    logic [DATA_W-1:0]    rd_mux;
    logic                 wr, ctrl_wr, stat_wr, go, start_ok, finish, err_set;
    logic                 busy_d, done_d, err_d, irq_en_d;

    always_comb begin
        wr      = cs & w;
        key_hit = '0;
        enc_hit = '0;
        wmask   = '0;
        for (int i = 0; i < KEY_WORDS; i++) key_hit[i] = (addr == ADDR_W'(i));
        for (int i = 0; i < MSG_WORDS; i++) enc_hit[i] = (addr == ADDR_W'(KEY_WORDS + i));
        for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{byte_en[b]}};
        ctrl_wr  = wr & (addr == CTRL_ADDR);
        stat_wr  = wr & (addr == STAT_ADDR) & byte_en[0];
        go       = ctrl_wr & byte_en[0] & wdata[0];
        start_ok = go & ~busy;
        finish   = busy & done_in;
        // A go that collides with done still sees busy, so it is dropped as an error.
        err_set  = (busy & wr & ((|key_hit) | (|enc_hit))) | (go & busy);

        busy_d = busy;
        if (finish)   busy_d = 1'b0;
        if (start_ok) busy_d = 1'b1;

        done_d = done_q;
        if (stat_wr && wdata[0]) done_d = 1'b0;
        if (finish)              done_d = 1'b1;

        err_d = err_q;
        if (stat_wr && wdata[1]) err_d = 1'b0;
        if (err_set)             err_d = 1'b1;
        err_d = err_d & IRQ_FEAT;

        irq_en_d = irq_en_q;
        if (ctrl_wr && byte_en[0]) irq_en_d = wdata[1];
        irq_en_d = irq_en_d & IRQ_FEAT;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < KEY_WORDS; i++)
            if (addr == ADDR_W'(i)) rd_mux = key_q[i];
        for (int i = 0; i < MSG_WORDS; i++) begin
            if (addr == ADDR_W'(KEY_WORDS + i))             rd_mux = enc_q[i];
            if (addr == ADDR_W'(KEY_WORDS + MSG_WORDS + i)) rd_mux = dec_q[i];
        end
        if (addr == CTRL_ADDR) rd_mux[1]   = irq_en_q;
        if (addr == STAT_ADDR) rd_mux[1:0] = {err_q, done_q};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
            for (int i = 0; i < MSG_WORDS; i++) begin
                enc_q[i] <= '0;
                dec_q[i] <= '0;
            end
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            busy        <= 1'b0;
            start_pulse <= 1'b0;
            irq         <= 1'b0;
            rdata       <= '0;
            rvalid      <= 1'b0;
        end else begin
            for (int i = 0; i < KEY_WORDS; i++)
                if (wr && key_hit[i] && !busy)
                    key_q[i] <= (key_q[i] & ~wmask) | (wdata & wmask);
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (wr && enc_hit[i] && !busy)
                    enc_q[i] <= (enc_q[i] & ~wmask) | (wdata & wmask);
                if (dec_valid)
                    dec_q[i] <= dec_in[i*DATA_W +: DATA_W];
            end
            done_q      <= done_d;
            err_q       <= err_d;
            irq_en_q    <= irq_en_d;
            busy        <= busy_d;
            start_pulse <= start_ok;
            irq         <= done_d & irq_en_d;
            rvalid      <= cs & r;
            if (cs && r) rdata <= rd_mux;
        end
    end

    always_comb begin
        key_out = '0;
        msg_out = '0;
        for (int i = 0; i < KEY_WORDS; i++) key_out[i*DATA_W +: DATA_W] = key_q[i];
        for (int i = 0; i < MSG_WORDS; i++) msg_out[i*DATA_W +: DATA_W] = enc_q[i];
    end

    assign ex = {dec_q[MSG_WORDS-1][DATA_W-1:DATA_W/2], dec_q[0][DATA_W/2-1:0]};

endmodule
